// File: rtl/cpu_pkg.sv
// Shared types and constants for the tiny CPU datapath (register file, ALU, control FSM).
// Status flags are packed {C,S,V,Z} with fixed bit positions.
package cpu_pkg;

   localparam int ST_C = 3;
   localparam int ST_S = 2;
   localparam int ST_V = 1;
   localparam int ST_Z = 0;

   localparam int NUM_REGS_DEFAULT = 8;
   localparam int DATA_W_DEFAULT   = 8;
   localparam int STATUS_W         = 4;

   typedef logic [7:0] data_t;
   typedef logic [3:0] status_t;

   // Load has the lowest priority, then set, then clear.
   function automatic status_t status_next(
      input status_t cur,
      input logic    load,
      input status_t load_val,
      input status_t set_mask,
      input status_t clr_mask
   );
      status_t base;
      if (load) begin
         base = load_val;
      end else begin
         base = cur;
      end
      return (base | set_mask) & ~clr_mask;
   endfunction

endpackage

// File: rtl/cpu_status_reg.sv
// 4-bit flag register with load/set/clear; kept standalone so it can be reused
// as an interrupt shadow copy.
module cpu_status_reg
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       st_we,
   input  logic [3:0] st_in,
   input  logic [3:0] flag_set,
   input  logic [3:0] flag_clr,
   output logic [3:0] st_out
);

   status_t st_d;
   status_t st_q;

   // Next-state flags from load, set and clear masks.
   always_comb begin
      st_d = status_next(st_q, st_we, st_in, flag_set, flag_clr);
   end

   // Flag register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q <= 4'h0;
      end else begin
         st_q <= st_d;
      end
   end

   assign st_out = st_q;

endmodule

// File: rtl/cpu_regfile.sv
// General-purpose register file with registered, write-first read ports and the
// status register feeding the ALU.
module cpu_regfile
   import cpu_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEFAULT,
   parameter int DATA_W   = DATA_W_DEFAULT,
   parameter int SEL_W    = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [SEL_W-1:0]  rd_a_sel,
   input  logic [SEL_W-1:0]  rd_b_sel,
   output logic [DATA_W-1:0] rd_a_data,
   output logic [DATA_W-1:0] rd_b_data,
   input  logic              wr_en,
   input  logic [SEL_W-1:0]  wr_sel,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              st_we,
   input  logic [3:0]        st_in,
   input  logic [3:0]        flag_set,
   input  logic [3:0]        flag_clr,
   output logic [3:0]        st_out
);

   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] rd_a_d;
   logic [DATA_W-1:0] rd_a_q;
   logic [DATA_W-1:0] rd_b_d;
   logic [DATA_W-1:0] rd_b_q;

   // Array next state: exactly one register changes on a write.
   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[wr_sel] = wr_data;
      end else begin
         regs_d = regs_q;
      end
   end

   // Operand capture; a same-edge write to the selected register wins over the array.
   always_comb begin
      rd_a_d = rd_a_q;
      rd_b_d = rd_b_q;
      if (rd_en) begin
         if (wr_en && (wr_sel == rd_a_sel)) begin
            rd_a_d = wr_data;
         end else begin
            rd_a_d = regs_q[rd_a_sel];
         end
         if (wr_en && (wr_sel == rd_b_sel)) begin
            rd_b_d = wr_data;
         end else begin
            rd_b_d = regs_q[rd_b_sel];
         end
      end else begin
         rd_a_d = rd_a_q;
         rd_b_d = rd_b_q;
      end
   end

   // Register array and operand flops; reset discards any write in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         rd_a_q <= '0;
         rd_b_q <= '0;
      end else begin
         regs_q <= regs_d;
         rd_a_q <= rd_a_d;
         rd_b_q <= rd_b_d;
      end
   end

   assign rd_a_data = rd_a_q;
   assign rd_b_data = rd_b_q;

   cpu_status_reg u_status (
      .clk      (clk),
      .rst_n    (rst_n),
      .st_we    (st_we),
      .st_in    (st_in),
      .flag_set (flag_set),
      .flag_clr (flag_clr),
      .st_out   (st_out)
   );

endmodule

// File: tb/tb_cpu_regfile.sv
// Self-checking bench for cpu_regfile: directed scenarios then randomized traffic,
// all compared against an array-based reference model.
module tb_cpu_regfile;

   logic       clk;
   logic       rst_n;
   logic       rd_en;
   logic [2:0] rd_a_sel;
   logic [2:0] rd_b_sel;
   logic [7:0] rd_a_data;
   logic [7:0] rd_b_data;
   logic       wr_en;
   logic [2:0] wr_sel;
   logic [7:0] wr_data;
   logic       st_we;
   logic [3:0] st_in;
   logic [3:0] flag_set;
   logic [3:0] flag_clr;
   logic [3:0] st_out;

   int n_cmp;
   int n_err;

   logic [7:0] m_regs [8];
   logic [7:0] m_a;
   logic [7:0] m_b;
   logic [3:0] m_st;

   cpu_regfile dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_en     (rd_en),
      .rd_a_sel  (rd_a_sel),
      .rd_b_sel  (rd_b_sel),
      .rd_a_data (rd_a_data),
      .rd_b_data (rd_b_data),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .st_we     (st_we),
      .st_in     (st_in),
      .flag_set  (flag_set),
      .flag_clr  (flag_clr),
      .st_out    (st_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rst_n = 1'b1; rd_en = 1'b0; wr_en = 1'b0; st_we = 1'b0;
      rd_a_sel = 3'd0; rd_b_sel = 3'd0; wr_sel = 3'd0; wr_data = 8'h00;
      st_in = 4'h0; flag_set = 4'h0; flag_clr = 4'h0;
   endtask

   // Update the model from the inputs now applied, clock once, then compare all outputs.
   task automatic tick();
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
         m_a = 8'h00; m_b = 8'h00; m_st = 4'h0;
      end else begin
         // write-first: the write lands before the read ports sample
         if (wr_en) m_regs[wr_sel] = wr_data;
         if (rd_en) begin
            m_a = m_regs[rd_a_sel];
            m_b = m_regs[rd_b_sel];
         end
         m_st = ((st_we ? st_in : m_st) | flag_set) & ~flag_clr;
      end
      @(posedge clk);
      #1;
      check("rd_a", rd_a_data, m_a);
      check("rd_b", rd_b_data, m_b);
      check("st", {4'h0, st_out}, {4'h0, m_st});
   endtask

   task automatic wr(input logic [2:0] sel, input logic [7:0] d);
      idle(); wr_en = 1'b1; wr_sel = sel; wr_data = d; tick();
   endtask

   task automatic rd(input logic [2:0] a, input logic [2:0] b);
      idle(); rd_en = 1'b1; rd_a_sel = a; rd_b_sel = b; tick();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_a = 8'h00; m_b = 8'h00; m_st = 4'h0;

      idle(); rst_n = 1'b0; #1;
      tick(); tick();
      check("reset_a", rd_a_data, 8'h00);
      check("reset_st", {4'h0, st_out}, 8'h00);

      // Reset overrides a write and a status load on the same edge.
      for (int i = 0; i < 8; i++) wr(3'(i), 8'hAA);
      rd(3'd4, 3'd7);
      check("pre_reset_a", rd_a_data, 8'hAA);
      idle(); st_we = 1'b1; st_in = 4'hF; tick();
      idle(); rst_n = 1'b0; wr_en = 1'b1; wr_sel = 3'd1; wr_data = 8'h55;
      st_we = 1'b1; st_in = 4'hF; tick();
      check("reset_st_zero", {4'h0, st_out}, 8'h00);
      for (int i = 0; i < 8; i += 2) rd(3'(i), 3'(i + 1));

      // Basic write then read.
      wr(3'd3, 8'h5C);
      rd(3'd3, 3'd0);
      check("basic_a", rd_a_data, 8'h5C);
      check("basic_b", rd_b_data, 8'h00);

      // Forwarding on both ports.
      wr(3'd2, 8'h11);
      idle(); wr_en = 1'b1; wr_sel = 3'd2; wr_data = 8'h7F;
      rd_en = 1'b1; rd_a_sel = 3'd2; rd_b_sel = 3'd2; tick();
      check("fwd_a", rd_a_data, 8'h7F);
      check("fwd_b", rd_b_data, 8'h7F);

      // Hold with rd_en low while the selected register changes.
      wr(3'd1, 8'h22);
      rd(3'd1, 3'd1);
      idle(); wr_en = 1'b1; wr_sel = 3'd1; wr_data = 8'h33; rd_a_sel = 3'd1; tick();
      check("hold_a", rd_a_data, 8'h22);
      idle(); rd_a_sel = 3'd1; tick();
      check("hold_a2", rd_a_data, 8'h22);
      rd(3'd1, 3'd0);
      check("hold_new", rd_a_data, 8'h33);

      // Status priority: load < set < clear.
      idle(); st_we = 1'b1; st_in = 4'h9; flag_set = 4'h2; flag_clr = 4'h8; tick();
      check("st_prio1", {4'h0, st_out}, 8'h03);
      idle(); flag_set = 4'h1; flag_clr = 4'h1; tick();
      check("st_prio2", {4'h0, st_out}, 8'h02);
      idle(); tick(); tick();
      check("st_hold", {4'h0, st_out}, 8'h02);

      // Reset mid-operation.
      idle(); rst_n = 1'b0; wr_en = 1'b1; wr_sel = 3'd5; wr_data = 8'hEE;
      st_we = 1'b1; st_in = 4'hF; tick();
      rd(3'd5, 3'd3);
      check("mid_reset_r5", rd_a_data, 8'h00);
      check("mid_reset_st", {4'h0, st_out}, 8'h00);

      // Randomized concurrent traffic.
      for (int n = 0; n < 400; n++) begin
         rst_n    = ($urandom_range(0, 49) != 0);
         rd_en    = 1'($urandom);
         wr_en    = 1'($urandom);
         rd_a_sel = 3'($urandom);
         rd_b_sel = ($urandom_range(0, 3) == 0) ? wr_sel : 3'($urandom);
         wr_sel   = 3'($urandom);
         if ($urandom_range(0, 3) == 0) rd_a_sel = wr_sel;
         wr_data  = 8'($urandom);
         st_we    = 1'($urandom);
         st_in    = 4'($urandom);
         flag_set = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         flag_clr = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
